// File: rtl/sd_crc_engine.sv
// SD-style CRC engine: folds DATA_W-bit beats into a Galois CRC register and
// serialises the finished CRC out MSB first with a ready/valid handshake.
module sd_crc_engine #(
  parameter int unsigned      CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h1021),
  parameter int unsigned      DATA_W = 8,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic             PAD    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              emit,
  input  logic              ordy,
  output logic [DATA_W-1:0] dout,
  output logic              ovld,
  output logic              olast,
  output logic [CRC_W-1:0]  crc,
  output logic              crc_ok,
  output logic              busy,
  output logic              err
);

  localparam int unsigned NB     = (CRC_W + DATA_W - 1) / DATA_W;
  localparam int unsigned TOT_W  = NB * DATA_W;
  localparam int unsigned BEAT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StEmit} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               err_q, err_d;
  logic [TOT_W-1:0]   frame;
  logic [TOT_W-1:0]   frame_sh;

  // MSB-first Galois update over one full beat.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] r,
                                            input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] v;
    logic             fb;
    v = r;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = v[CRC_W-1] ^ d[i];
      v  = (v << 1) ^ (fb ? POLY : '0);
    end
    return v;
  endfunction

  // State, CRC register, beat counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      crc_q   <= INIT;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; clr outranks everything except reset.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    beat_d  = beat_q;
    err_d   = err_q;
    if (clr) begin
      err_d  = 1'b0;
      beat_d = '0;
      if (en) begin
        crc_d   = fold(INIT, din);
        state_d = StAcc;
      end else begin
        crc_d   = INIT;
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle, StAcc: begin
          if (en) begin
            crc_d   = fold(crc_q, din);
            state_d = StAcc;
          end
          // Fold-then-emit: the register captures the folded value on this
          // edge and stays frozen for the whole emission.
          if (emit) begin
            state_d = StEmit;
            beat_d  = '0;
          end
        end
        StEmit: begin
          if (en || emit) err_d = 1'b1;
          if (ordy) begin
            if (beat_q == LAST_BEAT) begin
              state_d = StIdle;
              crc_d   = INIT;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output beat selection: the CRC left-aligned in a PAD-filled frame.
  always_comb begin
    frame                    = {TOT_W{PAD}};
    frame[TOT_W-1 -: CRC_W]  = crc_q;
    frame_sh                 = frame << (int'(beat_q) * int'(DATA_W));
    ovld                     = (state_q == StEmit);
    olast                    = ovld && (beat_q == LAST_BEAT);
    dout                     = ovld ? frame_sh[TOT_W-1 -: DATA_W] : '0;
  end

  assign crc    = crc_q;
  assign crc_ok = (crc_q == '0);
  assign busy   = (state_q != StIdle);
  assign err    = err_q;

endmodule

// File: tb/tb_sd_crc_engine.sv
// Self-checking bench for sd_crc_engine: CRC16/8-bit, CRC7/8-bit and CRC16/1-bit
// instances checked against a polynomial long-division reference model.
module tb_sd_crc_engine;

  logic        clk;
  logic        reset, clr, en, emit, ordy;
  logic [7:0]  din;
  logic        clr1, en1, emit1;
  logic [0:0]  din1;

  logic [7:0]  dout16, dout7;
  logic [0:0]  dout1;
  logic        ovld16, olast16, ok16, busy16, err16;
  logic        ovld7, olast7, ok7, busy7, err7;
  logic        ovld1, olast1, ok1, busy1, err1;
  logic [15:0] crc16, crc1;
  logic [6:0]  crc7;

  int tests = 0;
  int fails = 0;

  bit          msg8[$];
  bit          msg1[$];
  logic [15:0] e16, e7, e1;
  bit          act16, act7, act1;

  sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .DATA_W(8), .INIT(16'h0000), .PAD(1'b1)) u16 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .din(din), .emit(emit), .ordy(ordy),
    .dout(dout16), .ovld(ovld16), .olast(olast16), .crc(crc16), .crc_ok(ok16),
    .busy(busy16), .err(err16)
  );

  sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .DATA_W(8), .INIT(7'h00), .PAD(1'b1)) u7 (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .din(din), .emit(emit), .ordy(ordy),
    .dout(dout7), .ovld(ovld7), .olast(olast7), .crc(crc7), .crc_ok(ok7),
    .busy(busy7), .err(err7)
  );

  sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .DATA_W(1), .INIT(16'h0000), .PAD(1'b1)) u1 (
    .clk(clk), .reset(reset), .clr(clr1), .en(en1), .din(din1), .emit(emit1), .ordy(ordy),
    .dout(dout1), .ovld(ovld1), .olast(olast1), .crc(crc1), .crc_ok(ok1),
    .busy(busy1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remainder of M(x)*x^w divided by G(x) = x^w + poly, by long division.
  function automatic logic [15:0] crc_model(input bit q[$], input int w, input logic [15:0] poly);
    bit          d[$];
    logic [15:0] r;
    d = q;
    repeat (w) d.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      if (d[i]) begin
        d[i] = 1'b0;
        for (int j = 0; j < w; j++) d[i+1+j] = d[i+1+j] ^ poly[w-1-j];
      end
    end
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = d[q.size()+j];
    return r;
  endfunction

  // Beat k of the emitted stream: CRC bits MSB first, then 1-fill.
  function automatic logic [7:0] beat_of(input logic [15:0] c, input int w, input int dw,
                                         input int k);
    logic [7:0] r;
    int         pos;
    r = '0;
    for (int j = 0; j < dw; j++) begin
      pos = k * dw + j;
      r[dw-1-j] = (pos < w) ? c[w-1-pos] : 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed8(input logic [7:0] b);
    en  = 1'b1;
    din = b;
    tick();
    en  = 1'b0;
    for (int i = 7; i >= 0; i--) msg8.push_back(b[i]);
  endtask

  task automatic clear8();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    msg8.delete();
  endtask

  task automatic check_reset16(input string tag);
    check({tag, "_crc"}, crc16, 16'h0000);
    check({tag, "_ovld"}, ovld16, 1'b0);
    check({tag, "_olast"}, olast16, 1'b0);
    check({tag, "_dout"}, dout16, 8'h00);
    check({tag, "_busy"}, busy16, 1'b0);
    check({tag, "_err"}, err16, 1'b0);
    check({tag, "_ok"}, ok16, 1'b1);
  endtask

  // Drain all active emissions under random ordy, checking every beat.
  task automatic drain();
    int k16 = 0, k7 = 0, k1 = 0;
    bit f16, f7, f1, acc;
    f16 = !act16; f7 = !act7; f1 = !act1;
    for (int c = 0; c < 300 && !(f16 && f7 && f1); c++) begin
      if (!f16) begin
        if (k16 == 2) begin
          check("d16_end_ovld", ovld16, 1'b0); check("d16_end_crc", crc16, 16'h0000); f16 = 1;
        end else begin
          check("d16_ovld", ovld16, 1'b1); check("d16_dout", dout16, beat_of(e16, 16, 8, k16));
          check("d16_olast", olast16, k16 == 1); check("d16_frozen", crc16, e16);
        end
      end
      if (!f7) begin
        if (k7 == 1) begin
          check("d7_end_ovld", ovld7, 1'b0); check("d7_end_crc", crc7, 7'h00); f7 = 1;
        end else begin
          check("d7_ovld", ovld7, 1'b1); check("d7_dout", dout7, beat_of(e7, 7, 8, k7));
          check("d7_olast", olast7, 1'b1);
        end
      end
      if (!f1) begin
        if (k1 == 16) begin
          check("d1_end_ovld", ovld1, 1'b0); check("d1_end_crc", crc1, 16'h0000); f1 = 1;
        end else begin
          check("d1_ovld", ovld1, 1'b1); check("d1_dout", dout1, beat_of(e1, 16, 1, k1));
          check("d1_olast", olast1, k1 == 15); check("d1_frozen", crc1, e1);
        end
      end
      ordy = 1'($urandom_range(0, 1));
      acc  = ordy;
      tick();
      if (acc) begin
        if (!f16 && k16 < 2) k16++;
        if (!f7 && k7 < 1) k7++;
        if (!f1 && k1 < 16) k1++;
      end
    end
    ordy = 1'b0;
    check("drain_complete", {f16, f7, f1}, 3'b111);
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    reset = 1'b1; clr = 1'b0; en = 1'b0; emit = 1'b0; ordy = 1'b0; din = '0;
    clr1 = 1'b0; en1 = 1'b0; emit1 = 1'b0; din1 = '0;
    act16 = 0; act7 = 0; act1 = 0;
    tick(); tick();
    check_reset16("rst");
    check("rst7_crc", crc7, 7'h00); check("rst7_ovld", ovld7, 1'b0); check("rst7_ok", ok7, 1'b1);
    check("rst1_crc", crc1, 16'h0000); check("rst1_busy", busy1, 1'b0);
    reset = 1'b0;

    // "123456789" into both byte-wide instances, crc visible one cycle after en.
    clear8();
    for (int i = 0; i < 9; i++) begin
      feed8(8'h31 + 8'(i));
      check("acc16_step", crc16, crc_model(msg8, 16, 16'h1021));
    end
    check("acc16_check", crc16, 16'h31C3);
    check("acc7_model", crc7, crc_model(msg8, 7, 16'h0009));
    check("acc_busy", busy16, 1'b1);
    e16 = crc_model(msg8, 16, 16'h1021);
    e7  = crc_model(msg8, 7, 16'h0009);
    emit = 1'b1; tick(); emit = 1'b0;
    check("e16_b0", dout16, 8'h31); check("e16_b0_last", olast16, 1'b0);
    tick(); tick();
    check("e16_hold", dout16, 8'h31); check("e16_hold_crc", crc16, 16'h31C3);
    ordy = 1'b1; tick();
    check("e16_b1", dout16, 8'hC3); check("e16_b1_last", olast16, 1'b1);
    check("e7_done", ovld7, 1'b0);
    tick(); ordy = 1'b0;
    check("e16_idle", busy16, 1'b0); check("e16_reinit", crc16, 16'h0000);

    // SD command CRC7: CMD0.
    clear8();
    feed8(8'h40); for (int i = 0; i < 4; i++) feed8(8'h00);
    check("cmd0_crc7", crc7, 7'h4A);
    check("cmd0_model", crc7, crc_model(msg8, 7, 16'h0009));
    ordy = 1'b1; emit = 1'b1; tick(); emit = 1'b0;
    check("cmd0_ovld", ovld7, 1'b1); check("cmd0_dout", dout7, 8'h95);
    check("cmd0_olast", olast7, 1'b1);
    tick();
    check("cmd0_end", ovld7, 1'b0);
    tick(); ordy = 1'b0;

    // 512 bytes of FF, then append the CRC to get a zero residue.
    clear8();
    for (int i = 0; i < 512; i++) feed8(8'hFF);
    e16 = crc_model(msg8, 16, 16'h1021);
    check("ff512_crc", crc16, e16);
    check("ff512_const", crc16, 16'h7FA1);
    check("ff512_ok_low", ok16, 1'b0);
    feed8(e16[15:8]); feed8(e16[7:0]);
    check("ff512_ok", ok16, 1'b1);
    check("ff512_zero", crc16, 16'h0000);

    // Random messages, random gaps, optional en+emit on the last beat.
    for (int r = 0; r < 6; r++) begin
      clear8();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n - 1; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          tick();
          check("rnd_gap", crc16, crc_model(msg8, 16, 16'h1021));
        end
        feed8(8'($urandom));
        check("rnd_crc16", crc16, crc_model(msg8, 16, 16'h1021));
        check("rnd_crc7", crc7, crc_model(msg8, 7, 16'h0009));
      end
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b1; din = b; emit = 1'b1; tick(); en = 1'b0; emit = 1'b0;
        for (int i = 7; i >= 0; i--) msg8.push_back(b[i]);
      end else begin
        feed8(b);
        emit = 1'b1; tick(); emit = 1'b0;
      end
      e16 = crc_model(msg8, 16, 16'h1021);
      e7  = crc_model(msg8, 7, 16'h0009);
      act16 = 1; act7 = 1; act1 = 0;
      drain();
    end

    // Bit-serial instance, "123456789".
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    msg1.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'h31 + 8'(i);
      for (int j = 7; j >= 0; j--) begin
        en1 = 1'b1; din1 = b[j]; tick(); msg1.push_back(b[j]);
      end
    end
    en1 = 1'b0;
    e1 = crc_model(msg1, 16, 16'h1021);
    check("bit_crc", crc1, 16'h31C3);
    check("bit_model", crc1, e1);
    emit1 = 1'b1; tick(); emit1 = 1'b0;
    act16 = 0; act7 = 0; act1 = 1;
    drain();

    // clr together with en: register = fold(INIT, din).
    clear8();
    feed8(8'($urandom));
    b = 8'($urandom);
    clr = 1'b1; en = 1'b1; din = b; tick(); clr = 1'b0; en = 1'b0;
    msg8.delete();
    for (int i = 7; i >= 0; i--) msg8.push_back(b[i]);
    check("clren_crc16", crc16, crc_model(msg8, 16, 16'h1021));
    check("clren_crc7", crc7, crc_model(msg8, 7, 16'h0009));
    check("clren_busy", busy16, 1'b1);

    // en / emit during EMIT are ignored but flag err; clr clears it.
    e16 = crc_model(msg8, 16, 16'h1021);
    emit = 1'b1; tick(); emit = 1'b0;
    check("pre_err", err16, 1'b0);
    en = 1'b1; din = 8'($urandom); tick(); en = 1'b0;
    check("en_emit_err", err16, 1'b1); check("en_emit_crc", crc16, e16);
    check("en_emit_dout", dout16, e16[15:8]);
    emit = 1'b1; tick(); emit = 1'b0;
    check("emit_emit_ovld", ovld16, 1'b1); check("emit_emit_dout", dout16, e16[15:8]);
    tick();
    check("err_sticky", err16, 1'b1);
    clr = 1'b1; tick(); clr = 1'b0; msg8.delete();
    check("clr_emit_ovld", ovld16, 1'b0); check("clr_emit_err", err16, 1'b0);
    check("clr_emit_crc", crc16, 16'h0000); check("clr_emit_ovld7", ovld7, 1'b0);

    // Reset mid-accumulate, then mid-EMIT with every control asserted.
    feed8(8'($urandom)); feed8(8'($urandom));
    reset = 1'b1; tick(); reset = 1'b0; msg8.delete();
    check_reset16("rst_acc");
    feed8(8'($urandom));
    emit = 1'b1; tick(); emit = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    check("pre_rst_err", err16, 1'b1);
    reset = 1'b1; clr = 1'b1; en = 1'b1; emit = 1'b1; ordy = 1'b1; tick();
    reset = 1'b0; clr = 1'b0; en = 1'b0; emit = 1'b0; ordy = 1'b0; msg8.delete();
    check_reset16("rst_emit");
    check("rst_emit_ovld7", ovld7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_crc_engine.md
SD_CRC_ENGINE -- requirements
Module: sd_crc_engine

Parameters
REQ-001 SHALL provide CRC_W, default 16, CRC width in bits; legal values 7..16.
REQ-002 SHALL provide POLY, default 16'h1021, generator polynomial with the x^CRC_W term omitted; use 7'h09 for the SD command CRC.
REQ-003 SHALL provide DATA_W, default 8, input/output beat width; legal values are 1, 4 and 8.
REQ-004 SHALL provide INIT, default all-zeros, the register preset value.
REQ-005 SHALL provide PAD, default 1'b1, the fill value for the unused low bits of the final emitted beat (the SD end bit).

Interface
REQ-006 clk  in  1  system clock; every register updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clr  in  1  single-cycle pulse; presets the register to INIT and aborts any emit in progress.
REQ-009 en  in  1  accumulate strobe; folds din into the CRC this cycle.
REQ-010 din  in  DATA_W  data beat; MSB is the first bit on the wire.
REQ-011 emit  in  1  single-cycle pulse; starts serialising the CRC register out.
REQ-012 ordy  in  1  downstream ready for the current dout beat.
REQ-013 dout  out  DATA_W  emitted CRC beat, MSB first.
REQ-014 ovld  out  1  dout is valid.
REQ-015 olast  out  1  the current beat is the final emitted beat.
REQ-016 crc  out  CRC_W  current register contents, combinational from the register.
REQ-017 crc_ok  out  1  high when the register is zero (receive check passes).
REQ-018 busy  out  1  high while not in IDLE.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 The state machine SHALL have three states: IDLE, ACC and EMIT.
REQ-021 Accumulate SHALL perform an MSB-first Galois update over DATA_W bits in one cycle: per bit, fb = reg[MSB]^d, reg = (reg<<1)^(fb?POLY:0), truncated to CRC_W.
REQ-022 IDLE→ACC on en, with the data folded that same cycle; ACC stays in ACC on further en beats.
REQ-023 IDLE or ACC→EMIT on emit.
REQ-024 EMIT SHALL run NB = ceil(CRC_W/DATA_W) beats; beat k carries register bits [CRC_W-1-k*DATA_W -: DATA_W]; bits below bit 0 are filled with PAD.
REQ-025 In EMIT, ovld SHALL be 1; a beat SHALL advance only when ovld&ordy; olast SHALL be 1 on beat NB-1.
REQ-026 On the final beat, when ovld&ordy&olast, the state SHALL go to IDLE and the register SHALL reload INIT on that same edge.
REQ-027 dout SHALL hold stable while ovld&!ordy.
REQ-028 The register SHALL be frozen during EMIT; emission uses a beat counter, not a register shift.
REQ-029 Latency: the crc output SHALL reflect a beat one cycle after its en; the first dout beat SHALL be valid one cycle after emit.
REQ-030 clr together with en in one cycle: the register SHALL become INIT folded with din; state ACC.
REQ-031 clr with no en: register SHALL become INIT; state IDLE.
REQ-032 clr SHALL have priority over emit and over any emit in progress, with ovld low the next cycle.
REQ-033 en during EMIT SHALL be ignored and SHALL set err; emit during EMIT SHALL be ignored and SHALL set err.
REQ-034 en together with emit from IDLE/ACC: din SHALL be folded first, and emission SHALL use the updated register.
REQ-035 err SHALL clear only on reset or clr.
REQ-036 crc_ok SHALL be valid in every state.

Reset
REQ-037 While reset is high: register=INIT, state=IDLE, beat counter=0, dout=0, ovld=0, olast=0, err=0, busy=0; crc_ok = (INIT==0).
REQ-038 reset SHALL override clr, en and emit.
REQ-039 Reset during EMIT SHALL drop ovld on the next edge and discard the partial emission.

Verification
REQ-040 CRC_W=7, POLY=7'h09, DATA_W=8: en bytes 40 00 00 00 00, then emit with ordy=1 → one beat, dout=8'h95, olast=1, crc=7'h4A before emit.
REQ-041 CRC_W=16, POLY=16'h1021, DATA_W=8: ASCII "123456789" → crc=16'h31C3; emit → 8'h31 then 8'hC3, olast on the second beat.
REQ-042 CRC16 config: 512 beats of 8'hFF → crc=16'h7FA1; feed 8'h7F, 8'hA1 → crc_ok=1.
REQ-043 CRC16, DATA_W=1: the same 72 bits of "123456789" → 16'h31C3; emit gives 16 beats, dout held while ordy is toggled randomly.
REQ-044 Boundaries: clr+en same cycle → register = fold(INIT,din); en during EMIT → err=1, crc unchanged; clr mid-EMIT → ovld=0 next cycle, err=0.
REQ-045 Reset asserted mid-accumulate and again mid-EMIT → all outputs at their REQ-037 values on the next cycle.
